// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and encodings for the pipeline hazard unit:
//                sequencer state, forwarding select codes, load result source
//                and a saturating increment helper for the perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Sequencer state: normal flow, or inside a multi-cycle load-use bubble
    typedef enum logic [0:0] {
        HZ_RUN    = 1'b0,
        HZ_BUBBLE = 1'b1
    } hz_state_e;

    // Operand select codes for the E-stage ALU inputs
    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_W    = 2'b01;
    localparam logic [1:0] FWD_M    = 2'b10;

    // ResultSrcE value that identifies a load in E
    localparam logic [1:0] RES_LOAD = 2'b01;

    // Width of the load-use bubble counter (covers 1..7 cycles)
    localparam int BUB_CNT_W = 3;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_fwd_sel
//  Description : Forwarding select for one E-stage source operand. The M
//                stage result is the youngest and wins over W; register x0
//                is hard-wired to zero and is never forwarded.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_fwd_sel
    import hazard_pkg::*;
(
    input  logic [4:0] i_rs_addr_E,
    input  logic [4:0] i_rd_addr_M,
    input  logic       i_reg_write_M,
    input  logic [4:0] i_rd_addr_W,
    input  logic       i_reg_write_W,
    output logic [1:0] o_fwd_sel
);

    logic w_hit_m;
    logic w_hit_w;

    assign w_hit_m = i_reg_write_M && (i_rd_addr_M != 5'd0) && (i_rd_addr_M == i_rs_addr_E);
    assign w_hit_w = i_reg_write_W && (i_rd_addr_W != 5'd0) && (i_rd_addr_W == i_rs_addr_E);

    // Prioritised select: M beats W, otherwise read the register file
    always_comb begin
        o_fwd_sel = FWD_NONE;
        if (w_hit_m) begin
            o_fwd_sel = FWD_M;
        end else if (w_hit_w) begin
            o_fwd_sel = FWD_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Pipeline sequencer for the 5-stage core. Generates stall and
//                flush controls for the F/D/E/M registers and the E-stage
//                forwarding selects. Handles multi-cycle load-use bubbles,
//                taken branch/jump redirects and data-memory wait freezes.
//                Optional perf counters are built when HAZARD_PERF_CNT_EN is
//                defined; otherwise stall_cnt and flush_cnt read as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int         LOAD_LAT = 1,
    parameter logic [1:0] LOAD_SRC = RES_LOAD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr_D,
    input  logic [4:0]  rs2_addr_D,
    input  logic [4:0]  rs1_addr_E,
    input  logic [4:0]  rs2_addr_E,
    input  logic [4:0]  rd_addr_E,
    input  logic        RegWriteE,
    input  logic [1:0]  ResultSrcE,
    input  logic [4:0]  rd_addr_M,
    input  logic        RegWriteM,
    input  logic [4:0]  rd_addr_W,
    input  logic        RegWriteW,
    input  logic        PCSrcE,
    input  logic        mem_busy,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // Bubble cycles still owed after the detecting cycle
    localparam logic [BUB_CNT_W-1:0] c_BUB_RELOAD = BUB_CNT_W'(LOAD_LAT - 1);
    localparam bit                   c_MULTI_CYC  = (LOAD_LAT > 1);

    hz_state_e              r_state;
    logic [BUB_CNT_W-1:0]   r_cnt;

    logic       w_lu;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_stall_f;
    logic       w_stall_d;
    logic       w_stall_e;
    logic       w_stall_m;
    logic       w_flush_d;
    logic       w_flush_e;

    // ------------------------------------------------------------------
    // Forwarding selects, one instance per E-stage source operand
    // ------------------------------------------------------------------
    hazard_fwd_sel u_fwd_a (
        .i_rs_addr_E   (rs1_addr_E),
        .i_rd_addr_M   (rd_addr_M),
        .i_reg_write_M (RegWriteM),
        .i_rd_addr_W   (rd_addr_W),
        .i_reg_write_W (RegWriteW),
        .o_fwd_sel     (w_fwd_a)
    );

    hazard_fwd_sel u_fwd_b (
        .i_rs_addr_E   (rs2_addr_E),
        .i_rd_addr_M   (rd_addr_M),
        .i_reg_write_M (RegWriteM),
        .i_rd_addr_W   (rd_addr_W),
        .i_reg_write_W (RegWriteW),
        .o_fwd_sel     (w_fwd_b)
    );

    // A load in E whose destination is read by the instruction in D
    assign w_lu = RegWriteE && (ResultSrcE == LOAD_SRC) && (rd_addr_E != 5'd0) &&
                  ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));

    // Stall/flush decode in priority order: memory wait, redirect, load-use
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_stall_e = 1'b0;
        w_stall_m = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (mem_busy) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_stall_e = 1'b1;
            w_stall_m = 1'b1;
        end else if (PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else if ((r_state == HZ_RUN && w_lu) || (r_state == HZ_BUBBLE)) begin
            w_stall_f = 1'b1;
            w_stall_d = 1'b1;
            w_flush_e = 1'b1;
        end
    end

    // Sequencer state and bubble countdown; frozen while memory is busy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= HZ_RUN;
            r_cnt   <= '0;
        end else if (mem_busy) begin
            r_state <= r_state;
            r_cnt   <= r_cnt;
        end else if (PCSrcE) begin
            r_state <= HZ_RUN;
            r_cnt   <= '0;
        end else if (r_state == HZ_RUN) begin
            if (w_lu && c_MULTI_CYC) begin
                r_state <= HZ_BUBBLE;
                r_cnt   <= c_BUB_RELOAD;
            end
        end else begin
            if (r_cnt <= BUB_CNT_W'(1)) begin
                r_state <= HZ_RUN;
                r_cnt   <= '0;
            end else begin
                r_cnt   <= r_cnt - BUB_CNT_W'(1);
            end
        end
    end

    // Every control output is forced low while reset is held
    assign StallF    = rst & w_stall_f;
    assign StallD    = rst & w_stall_d;
    assign StallE    = rst & w_stall_e;
    assign StallM    = rst & w_stall_m;
    assign FlushD    = rst & w_flush_d;
    assign FlushE    = rst & w_flush_e;
    assign ForwardAE = rst ? w_fwd_a : FWD_NONE;
    assign ForwardBE = rst ? w_fwd_b : FWD_NONE;

`ifdef HAZARD_PERF_CNT_EN
    logic        w_lu_stall;
    logic        w_redirect;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // Cycles where the load-use bubble is actually applied
    assign w_lu_stall = !mem_busy && !PCSrcE &&
                        ((r_state == HZ_RUN && w_lu) || (r_state == HZ_BUBBLE));
    assign w_redirect = PCSrcE && !mem_busy;

    // Saturating perf counters for load-use stall cycles and redirects
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_lu_stall) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (w_redirect) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Directed self-checking bench for hazard_ctrl. Two instances
//                (LOAD_LAT=1 and LOAD_LAT=3) share one set of stimulus.
//                Perf counter expectations follow HAZARD_PERF_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {StallF, StallD, StallE, StallM, FlushD, FlushE}
    localparam logic [5:0] V_IDLE  = 6'b000000;
    localparam logic [5:0] V_LU    = 6'b110001;
    localparam logic [5:0] V_BUSY  = 6'b111100;
    localparam logic [5:0] V_REDIR = 6'b000011;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E, rd_addr_E;
    logic       RegWriteE;
    logic [1:0] ResultSrcE;
    logic [4:0] rd_addr_M, rd_addr_W;
    logic       RegWriteM, RegWriteW, PCSrcE, mem_busy;

    logic        sf1, sd1, se1, sm1, fd1, fe1;
    logic        sf3, sd3, se3, sm3, fd3, fe3;
    logic [1:0]  fa1, fb1, fa3, fb3;
    logic [31:0] sc1, fc1, sc3, fc3;

    wire [5:0] v1 = {sf1, sd1, se1, sm1, fd1, fe1};
    wire [5:0] v3 = {sf3, sd3, se3, sm3, fd3, fe3};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .LOAD_SRC(2'b01)) u_lat1 (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_addr_E(rd_addr_E), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .rd_addr_M(rd_addr_M), .RegWriteM(RegWriteM),
        .rd_addr_W(rd_addr_W), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .mem_busy(mem_busy),
        .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
        .FlushD(fd1), .FlushE(fe1),
        .ForwardAE(fa1), .ForwardBE(fb1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    hazard_ctrl #(.LOAD_LAT(3), .LOAD_SRC(2'b01)) u_lat3 (
        .clk(clk), .rst(rst),
        .rs1_addr_D(rs1_addr_D), .rs2_addr_D(rs2_addr_D),
        .rs1_addr_E(rs1_addr_E), .rs2_addr_E(rs2_addr_E),
        .rd_addr_E(rd_addr_E), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
        .rd_addr_M(rd_addr_M), .RegWriteM(RegWriteM),
        .rd_addr_W(rd_addr_W), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .mem_busy(mem_busy),
        .StallF(sf3), .StallD(sd3), .StallE(se3), .StallM(sm3),
        .FlushD(fd3), .FlushE(fe3),
        .ForwardAE(fa3), .ForwardBE(fb3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rs1_addr_D = 5'd0; rs2_addr_D = 5'd0;
        rs1_addr_E = 5'd0; rs2_addr_E = 5'd0;
        rd_addr_E  = 5'd0; RegWriteE  = 1'b0; ResultSrcE = 2'b00;
        rd_addr_M  = 5'd0; RegWriteM  = 1'b0;
        rd_addr_W  = 5'd0; RegWriteW  = 1'b0;
        PCSrcE     = 1'b0; mem_busy   = 1'b0;
    endtask

    // Load into x7 in E while D reads x7 through rs2
    task automatic set_lu();
        RegWriteE  = 1'b1;
        ResultSrcE = 2'b01;
        rd_addr_E  = 5'd7;
        rs2_addr_D = 5'd7;
    endtask

    initial begin
        // ---------------- reset state ----------------
        idle();
        rst = 1'b0;
        mem_busy = 1'b1; PCSrcE = 1'b1; set_lu();
        rs1_addr_E = 5'd5; rd_addr_M = 5'd5; RegWriteM = 1'b1;
        #3;
        chk("rst_ctl1", 32'(v1), 32'(V_IDLE));
        chk("rst_ctl3", 32'(v3), 32'(V_IDLE));
        chk("rst_fwdA", 32'(fa1), 32'd0);
        chk("rst_scnt", sc3, 32'd0);
        chk("rst_fcnt", fc3, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); idle(); rst = 1'b1;
        #1;
        chk("run_idle1", 32'(v1), 32'(V_IDLE));
        chk("run_idle3", 32'(v3), 32'(V_IDLE));

        // ---------------- forwarding ----------------
        @(negedge clk); idle();
        rs1_addr_E = 5'd5; rd_addr_M = 5'd5; RegWriteM = 1'b1; rd_addr_W = 5'd5; RegWriteW = 1'b1;
        #1;
        chk("fwdA_M_over_W", 32'(fa1), 32'(2'b10));
        chk("fwdB_none", 32'(fb1), 32'(2'b00));
        rd_addr_M = 5'd0; #1;
        chk("fwdA_W", 32'(fa1), 32'(2'b01));
        rs2_addr_E = 5'd5; rd_addr_M = 5'd5; RegWriteW = 1'b0; #1;
        chk("fwdB_M", 32'(fb3), 32'(2'b10));
        RegWriteM = 1'b0; #1;
        chk("fwdB_noWE", 32'(fb3), 32'(2'b00));
        rs1_addr_E = 5'd0; rd_addr_M = 5'd0; RegWriteM = 1'b1; rd_addr_W = 5'd0; RegWriteW = 1'b1; #1;
        chk("fwdA_x0", 32'(fa1), 32'(2'b00));

        // ---------------- non-hazards ----------------
        @(negedge clk); idle(); set_lu(); ResultSrcE = 2'b00; #1;
        chk("nonload_nostall", 32'(v3), 32'(V_IDLE));
        @(negedge clk); idle(); set_lu(); rd_addr_E = 5'd0; rs2_addr_D = 5'd0; #1;
        chk("x0_load_nostall", 32'(v3), 32'(V_IDLE));

        // ---------------- load-use, LOAD_LAT 1 and 3 ----------------
        @(negedge clk); idle(); set_lu(); #1;
        chk("lu_c1_lat1", 32'(v1), 32'(V_LU));
        chk("lu_c1_lat3", 32'(v3), 32'(V_LU));
        @(negedge clk); idle(); #1;
        chk("lu_c2_lat1", 32'(v1), 32'(V_IDLE));
        chk("lu_c2_lat3", 32'(v3), 32'(V_LU));
        @(negedge clk); idle(); #1;
        chk("lu_c3_lat3", 32'(v3), 32'(V_LU));
        @(negedge clk); idle(); #1;
        chk("lu_c4_lat3", 32'(v3), 32'(V_IDLE));
        chk("scnt_lat1_a", sc1, PERF ? 32'd1 : 32'd0);
        chk("scnt_lat3_a", sc3, PERF ? 32'd3 : 32'd0);

        // ---------------- redirect beats load-use ----------------
        @(negedge clk); idle(); set_lu(); PCSrcE = 1'b1; #1;
        chk("redir_lat1", 32'(v1), 32'(V_REDIR));
        chk("redir_lat3", 32'(v3), 32'(V_REDIR));
        @(negedge clk); idle(); #1;
        chk("redir_run3", 32'(v3), 32'(V_IDLE));
        chk("fcnt_lat1", fc1, PERF ? 32'd1 : 32'd0);
        chk("fcnt_lat3", fc3, PERF ? 32'd1 : 32'd0);

        // ---------------- mem_busy pauses a bubble ----------------
        @(negedge clk); idle(); set_lu(); #1;
        chk("busy_lu_lat3", 32'(v3), 32'(V_LU));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle(); mem_busy = 1'b1; #1;
            chk("busy_frz_lat3", 32'(v3), 32'(V_BUSY));
            chk("busy_frz_lat1", 32'(v1), 32'(V_BUSY));
        end
        @(negedge clk); idle(); #1;
        chk("busy_res1_lat3", 32'(v3), 32'(V_LU));
        chk("busy_res1_lat1", 32'(v1), 32'(V_IDLE));
        @(negedge clk); idle(); #1;
        chk("busy_res2_lat3", 32'(v3), 32'(V_LU));
        @(negedge clk); idle(); #1;
        chk("busy_done_lat3", 32'(v3), 32'(V_IDLE));
        chk("scnt_lat1_b", sc1, PERF ? 32'd2 : 32'd0);
        chk("scnt_lat3_b", sc3, PERF ? 32'd6 : 32'd0);

        // ---------------- reset pulse mid-bubble ----------------
        @(negedge clk); idle(); set_lu(); #1;
        chk("rstb_lu_lat3", 32'(v3), 32'(V_LU));
        @(negedge clk);
        rs1_addr_E = 5'd5; rd_addr_M = 5'd5; RegWriteM = 1'b1;
        rst = 1'b0; #1;
        chk("rstb_async3", 32'(v3), 32'(V_IDLE));
        chk("rstb_fwd3", 32'(fa3), 32'd0);
        chk("rstb_scnt3", sc3, 32'd0);
        chk("rstb_fcnt1", fc1, 32'd0);
        @(negedge clk); idle(); rst = 1'b1; #1;
        chk("rstb_run3", 32'(v3), 32'(V_IDLE));
        @(negedge clk); idle(); set_lu(); #1;
        chk("rstb_newlu3", 32'(v3), 32'(V_LU));
        @(negedge clk); idle(); #1;
        chk("rstb_newbub3", 32'(v3), 32'(V_LU));
        chk("rstb_newbub1", 32'(v1), 32'(V_IDLE));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
